// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle restoring 32-bit divider with MIPS DIV/DIVU semantics
// (quotient truncates toward zero, remainder takes the dividend's sign).
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dq_q, dq_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             negq_q, negq_d, negr_q, negr_d, zero_q, zero_d, dbz_q, dbz_d;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted, diff;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    a_neg       = is_signed & dividend[WIDTH-1];
    b_neg       = is_signed & divisor[WIDTH-1];
    shifted     = {rem_q, dq_q[WIDTH-1]};
    diff        = shifted - {1'b0, dvs_q};
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dq_d    = a_neg ? -dividend : dividend;
          dvs_d   = b_neg ? -divisor : divisor;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          zero_d  = divisor == '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // a borrow out of the trial subtraction means restore
        rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        dq_d    = {dq_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'(WIDTH - 1) ? FIXUP : RUN;
      end
      FIXUP: begin
        quotient_d  = negq_q ? -dq_q : dq_q;
        remainder_d = negr_q ? -rem_q : rem_q;
        dbz_d       = zero_q;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end
  assign busy        = state_q == RUN || state_q == FIXUP;
  assign done        = state_q == DONE;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: random and directed divisions checked by a scoreboard
// against a plain-arithmetic MIPS DIV/DIVU model.
module tb_iterative_divider;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          c;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, run = 0;
  iterative_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, want);
    end
  endtask
  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sa, sb;
    sa = a;
    sb = b;
    e.z = b == 0;
    e.c = 0;
    if (b == 0) begin
      e.q = (s && (a[31] ^ b[31])) ? 32'd1 : 32'hFFFF_FFFF;
      e.r = a;
    end else if (!s) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 0;
    end else begin
      e.q = sa / sb;
      e.r = sa % sb;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got=1 exp=0");
        end else begin
          e = exp_q.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
          chk("latency", cyc, e.c);
          chk("busy_cycles", run, 33);
          chk("busy_in_done", 32'(busy), 0);
        end
      end
      run = busy ? run + 1 : 0;
    end
  end
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(s, a, b);
    e.c = cyc + 34;
    exp_q.push_back(e);
    start = 1'b1;
    is_signed = s;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=0 exp=1");
    end
  endtask
  task automatic run_one(input logic s, input logic [31:0] a, input logic [31:0] b);
    issue(s, a, b);
    wait_done();
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    chk("reset_dbz", 32'(div_by_zero), 0);
    run_one(0, 100, 7);
    run_one(1, 32'hFFFF_FFF9, 2);
    run_one(1, 7, 32'hFFFF_FFFE);
    run_one(0, 5, 0);
    run_one(1, 32'hFFFF_FFFB, 0);
    run_one(1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_one(0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(0, 1000, 9);
    repeat (4) @(negedge clk);
    chk("busy_mid_op", 32'(busy), 1);
    start = 1'b1;
    is_signed = 1'b1;
    dividend = 32'h1234;
    divisor = 3;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(1, 32'h7FFF_FFFF, 32'hFFFF_FFF0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    repeat (40) @(negedge clk);
    issue(0, 100, 7);
    wait_done();
    issue(0, 20, 3);
    wait_done();
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: b = a >> $urandom_range(0, 31);
        default: ;
      endcase
      issue(1'($urandom), a, b);
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_results got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
